serial_pattern_detector: RTL

//  Consumes the 1-bit serial stream (inp, one bit per clk) produced by the stimulus stage.

---
 rtl/serial_pattern_detector_pkg.sv | 19 +
 rtl/serial_pattern_detector_if.sv | 32 +++
 rtl/serial_pattern_detector_sat_counter.sv | 23 ++
 rtl/serial_pattern_detector.sv | 78 +++++++
 4 files changed

// File: rtl/serial_pattern_detector_pkg.sv
// Shared constants and types for the serial pattern detector.
// Defaults describe the 4-bit 1011 detector with an 8-bit match count.
package pattern_pkg;

  localparam int         DEF_PAT_LEN = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;
  localparam int         DEF_CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILLING,
    ST_ARMED
  } fill_st_t;

  function automatic int fill_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_pattern_detector_if.sv
// Serial bit stream in, match pulse / armed flag / match count out.
// The master drives bits and soft clear; the slave is the detector.
interface serial_pattern_detector_if #(
  parameter int CNT_W = 8
);

  logic             inp;
  logic             in_valid;
  logic             clr;
  logic             match;
  logic             armed;
  logic [CNT_W-1:0] match_count;

  modport master (
    output inp,
    output in_valid,
    output clr,
    input  match,
    input  armed,
    input  match_count
  );

  modport slave (
    input  inp,
    input  in_valid,
    input  clr,
    output match,
    output armed,
    output match_count
  );

endinterface

// File: rtl/serial_pattern_detector_sat_counter.sv
// Up-counter that sticks at all-ones; cleared by reset or clr.
// Reset and clr are both synchronous.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: shift history plus fill level, registered
// one-cycle match pulse and saturating match count.
module serial_pattern_detector
  import pattern_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  serial_pattern_detector_if.slave   bus
);

  localparam int FW = fill_w(PAT_LEN);

  logic [PAT_LEN-2:0] hist;
  logic [FW-1:0]      fill;
  logic [FW-1:0]      fill_next;
  logic [PAT_LEN-1:0] shifted;
  logic               hit;
  fill_st_t           st_next;

  assign shifted = {hist, bus.inp};

  // hist bits beyond the fill level are stale, so fill gates the compare
  assign hit = bus.in_valid
             & (fill >= FW'(PAT_LEN - 1))
             & (shifted == PATTERN);

  always_comb begin
    fill_next = fill;
    if (bus.in_valid) begin
      if (hit && !OVERLAP) begin
        fill_next = '0;
      end else if (fill != FW'(PAT_LEN)) begin
        fill_next = fill + FW'(1);
      end
    end
  end

  always_comb begin
    st_next = ST_FILLING;
    if (fill_next == FW'(PAT_LEN)) begin
      st_next = ST_ARMED;
    end else if (fill_next == '0) begin
      st_next = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr) begin
      hist      <= '0;
      fill      <= '0;
      bus.match <= 1'b0;
      bus.armed <= 1'b0;
    end else begin
      bus.match <= hit;
      bus.armed <= (st_next == ST_ARMED);
      fill      <= fill_next;
      if (bus.in_valid) begin
        hist <= shifted[PAT_LEN-2:0];
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clr),
    .inc   (hit),
    .q     (bus.match_count)
  );

endmodule
